// File: rtl/regbank_wr_arbiter.sv
// Shared write port for the register bank. Each cycle one requester is picked by round-robin or fixed priority.
// The chosen write is registered for one cycle before it commits. The read port is combinational.
module regbank_wr_arbiter #(
    parameter  int NREQ = 4,
    parameter  int NREG = 8,
    parameter  int DW   = 8,
    localparam int AW   = $clog2(NREG),
    localparam int IW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prio_mode,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [IW-1:0]      gnt_id,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [DW-1:0]      rd_data,
    output logic               busy
);

    logic [NREQ-1:0] r_gnt;
    logic [IW-1:0]   r_gnt_id;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [DW-1:0]   r_wr_data;
    logic [IW-1:0]   r_ptr;
    logic [DW-1:0]   r_bank [NREG];

    logic [NREQ-1:0] w_elig;
    logic [IW:0]     w_rr_pick;
    logic [IW:0]     w_fp_pick;
    logic [IW:0]     w_pick;
    logic            w_found;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_ptr_nxt;
    logic [AW-1:0]   w_addr_arr [NREQ];
    logic [DW-1:0]   w_data_arr [NREQ];

    // Result format {found, index}. The search runs downward so the candidate closest to ptr is written last.
    function automatic logic [IW:0] pick_rr(input logic [NREQ-1:0] elig,
                                            input logic [IW-1:0]   ptr);
        logic [IW:0] res;
        int          j;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (elig[IW'(j)]) begin
                res = {1'b1, IW'(j)};
            end
        end
        return res;
    endfunction

    function automatic logic [IW:0] pick_fixed(input logic [NREQ-1:0] elig);
        logic [IW:0] res;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (elig[k]) begin
                res = {1'b1, IW'(k)};
            end
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
        return (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] res;
        res      = '0;
        res[idx] = 1'b1;
        return res;
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr_arr[g] = req_addr[g*AW +: AW];
        assign w_data_arr[g] = req_data[g*DW +: DW];
    end

    // A requester whose grant is currently visible is masked. This stops a stale held request from being granted twice.
    assign w_elig    = req & ~r_gnt;
    assign w_rr_pick = pick_rr(w_elig, r_ptr);
    assign w_fp_pick = pick_fixed(w_elig);
    assign w_pick    = prio_mode ? w_fp_pick : w_rr_pick;
    assign w_found   = w_pick[IW];
    assign w_idx     = w_pick[IW-1:0];
    assign w_ptr_nxt = next_ptr(w_idx);

    // Arbitration stage: grant, write staging and pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_ptr     <= '0;
        end else if (w_found) begin
            r_gnt     <= onehot(w_idx);
            r_gnt_id  <= w_idx;
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_addr_arr[w_idx];
            r_wr_data <= w_data_arr[w_idx];
            r_ptr     <= w_ptr_nxt;
        end else begin
            r_gnt   <= '0;
            r_wr_en <= 1'b0;
        end
    end

    // Commit stage: the staged write lands in the bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_bank[i] <= '0;
            end
        end else if (r_wr_en) begin
            r_bank[r_wr_addr] <= r_wr_data;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign rd_data = r_bank[rd_addr];
    assign busy    = |req;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Testbench for regbank_wr_arbiter: directed scenarios, then randomized traffic compared against a
// behavioural model of grants, pointer and bank.
module tb_regbank_wr_arbiter;
    localparam int NREQ = 4;
    localparam int NREG = 8;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int IW   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               prio_mode;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [IW-1:0]      gnt_id;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic [AW-1:0]      rd_addr;
    logic [DW-1:0]      rd_data;
    logic               busy;

    int n_vec = 0;
    int n_bad = 0;

    int              m_ptr;
    int              m_gnt_id;
    logic [NREQ-1:0] m_gnt;
    logic            m_wr_en;
    logic [AW-1:0]   m_wr_addr;
    logic [DW-1:0]   m_wr_data;
    logic [DW-1:0]   m_bank [NREG];

    regbank_wr_arbiter #(.NREQ(NREQ), .NREG(NREG), .DW(DW)) dut (
        .clk(clk), .rst(rst), .prio_mode(prio_mode), .req(req),
        .req_addr(req_addr), .req_data(req_data), .gnt(gnt), .gnt_id(gnt_id),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, expected finish");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr = (req_addr & ~((NREQ*AW)'(7) << (i*AW))) | ((NREQ*AW)'(a) << (i*AW));
        req_data = (req_data & ~((NREQ*DW)'(8'hFF) << (i*DW))) | ((NREQ*DW)'(d) << (i*DW));
    endtask

    task automatic model_reset();
        m_ptr = 0; m_gnt_id = 0; m_gnt = '0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
        for (int a = 0; a < NREG; a++) m_bank[a] = '0;
    endtask

    // One clock edge of the specified behaviour: the previous write commits, then the next winner is chosen.
    task automatic model_edge();
        logic [NREQ-1:0] elig;
        int w;
        if (m_wr_en) m_bank[m_wr_addr] = m_wr_data;
        elig = req & ~m_gnt;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = prio_mode ? k : (m_ptr + k) % NREQ;
            if (w < 0 && elig[IW'(i)]) w = i;
        end
        if (w >= 0) begin
            m_gnt     = NREQ'(1) << w;
            m_gnt_id  = w;
            m_wr_en   = 1'b1;
            m_wr_addr = AW'(req_addr >> (w*AW));
            m_wr_data = DW'(req_data >> (w*DW));
            m_ptr     = (w + 1) % NREQ;
        end else begin
            m_gnt   = '0;
            m_wr_en = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = '0; prio_mode = 1'b0; req_addr = '0; req_data = '0; rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; prio_mode = 1'b0; req_addr = '0; req_data = '0; rd_addr = '0;
        #1;
        n_vec++; if (gnt !== 4'b0000 || wr_en !== 1'b0 || gnt_id !== 2'd0) begin
            n_bad++; $display("FAIL reset_ctrl: got gnt=%b wr_en=%b gnt_id=%0d, expected 0000/0/0", gnt, wr_en, gnt_id); end
        n_vec++; if (wr_addr !== 3'd0 || wr_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_wr: got addr=%0d data=%h, expected 0/00", wr_addr, wr_data); end
        req = 4'b0001; set_req(0, 3'd2, 8'h55);
        tick();
        n_vec++; if (gnt !== 4'b0000 || wr_en !== 1'b0) begin
            n_bad++; $display("FAIL reset_no_grant: got gnt=%b wr_en=%b, expected 0000/0", gnt, wr_en); end
        n_vec++; if (busy !== 1'b1) begin
            n_bad++; $display("FAIL reset_busy: got %b expected 1", busy); end
        for (int a = 0; a < NREG; a++) begin
            rd_addr = AW'(a);
            #1;
            n_vec++; if (rd_data !== 8'h00) begin
                n_bad++; $display("FAIL reset_rd[%0d]: got %h expected 00", a, rd_data); end
        end
        rst = 1'b0;
        tick();
        n_vec++; if (wr_en !== 1'b1 || gnt !== 4'b0001 || wr_addr !== 3'd2 || wr_data !== 8'h55) begin
            n_bad++; $display("FAIL reset_first_grant: got wr_en=%b gnt=%b addr=%0d data=%h, expected 1/0001/2/55", wr_en, gnt, wr_addr, wr_data); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (gnt !== 4'b0000 || wr_en !== 1'b0 || wr_addr !== 3'd0 || wr_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_async: got gnt=%b wr_en=%b addr=%0d data=%h, expected all 0", gnt, wr_en, wr_addr, wr_data); end
        req = '0;
        tick();
        rst = 1'b0;
        rd_addr = 3'd2;
        #1;
        n_vec++; if (rd_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_dropped: got %h expected 00", rd_data); end
        tick();
        n_vec++; if (rd_data !== 8'h00 || wr_en !== 1'b0) begin
            n_bad++; $display("FAIL reset_dropped_late: got rd=%h wr_en=%b, expected 00/0", rd_data, wr_en); end
    endtask

    task automatic test_single();
        apply_reset();
        req = 4'b0100; set_req(2, 3'd5, 8'hA7); rd_addr = 3'd5;
        tick();
        n_vec++; if (gnt !== 4'b0100 || gnt_id !== 2'd2 || wr_en !== 1'b1) begin
            n_bad++; $display("FAIL single_grant: got gnt=%b id=%0d wr_en=%b, expected 0100/2/1", gnt, gnt_id, wr_en); end
        n_vec++; if (wr_addr !== 3'd5 || wr_data !== 8'hA7 || rd_data !== 8'h00) begin
            n_bad++; $display("FAIL single_stage: got addr=%0d data=%h rd=%h, expected 5/a7/00", wr_addr, wr_data, rd_data); end
        tick();
        n_vec++; if (gnt !== 4'b0000 || wr_en !== 1'b0 || wr_addr !== 3'd5) begin
            n_bad++; $display("FAIL single_masked: got gnt=%b wr_en=%b addr=%0d, expected 0000/0/5", gnt, wr_en, wr_addr); end
        n_vec++; if (rd_data !== 8'hA7) begin
            n_bad++; $display("FAIL single_commit: got %h expected a7", rd_data); end
        req = '0;
        tick();
        n_vec++; if (gnt !== 4'b0000 || rd_data !== 8'hA7 || busy !== 1'b0) begin
            n_bad++; $display("FAIL single_idle: got gnt=%b rd=%h busy=%b, expected 0000/a7/0", gnt, rd_data, busy); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), DW'(8'h30 + i));
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_vec++; if (gnt !== NREQ'(1 << (k % 4)) || gnt_id !== IW'(k % 4) || wr_en !== 1'b1) begin
                n_bad++; $display("FAIL rr_order[%0d]: got gnt=%b id=%0d wr_en=%b, expected id %0d", k, gnt, gnt_id, wr_en, k % 4); end
            n_vec++; if (wr_data !== DW'(8'h30 + k % 4)) begin
                n_bad++; $display("FAIL rr_data[%0d]: got %h expected %h", k, wr_data, 8'h30 + k % 4); end
        end
    endtask

    task automatic test_fixed_priority();
        logic [IW-1:0] exp_id [3];
        exp_id = '{2'd1, 2'd3, 2'd1};
        apply_reset();
        prio_mode = 1'b1; req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (gnt_id !== exp_id[k] || wr_en !== 1'b1) begin
                n_bad++; $display("FAIL fixed_alt[%0d]: got id=%0d wr_en=%b expected %0d/1", k, gnt_id, wr_en, exp_id[k]); end
        end
        prio_mode = 1'b0; req = 4'b1011;
        tick();
        n_vec++; if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            n_bad++; $display("FAIL fixed_to_rr: got gnt=%b id=%0d expected 1000/3", gnt, gnt_id); end
        tick();
        n_vec++; if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            n_bad++; $display("FAIL fixed_to_rr_next: got gnt=%b id=%0d expected 0001/0", gnt, gnt_id); end
    endtask

    task automatic test_collision();
        apply_reset();
        set_req(0, 3'd3, 8'h11); set_req(1, 3'd3, 8'h22); req = 4'b0011; rd_addr = 3'd3;
        tick();
        n_vec++; if (gnt_id !== 2'd0 || wr_data !== 8'h11 || wr_addr !== 3'd3) begin
            n_bad++; $display("FAIL coll_first: got id=%0d data=%h addr=%0d expected 0/11/3", gnt_id, wr_data, wr_addr); end
        tick();
        n_vec++; if (gnt_id !== 2'd1 || wr_data !== 8'h22 || rd_data !== 8'h11) begin
            n_bad++; $display("FAIL coll_second: got id=%0d data=%h rd=%h expected 1/22/11", gnt_id, wr_data, rd_data); end
        req = '0;
        tick();
        n_vec++; if (rd_data !== 8'h22 || wr_en !== 1'b0) begin
            n_bad++; $display("FAIL coll_final: got rd=%h wr_en=%b expected 22/0", rd_data, wr_en); end
    endtask

    task automatic test_wrap();
        apply_reset();
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        req = 4'b1001;
        tick();
        n_vec++; if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            n_bad++; $display("FAIL wrap_first: got gnt=%b id=%0d expected 1000/3", gnt, gnt_id); end
        tick();
        n_vec++; if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            n_bad++; $display("FAIL wrap_second: got gnt=%b id=%0d expected 0001/0", gnt, gnt_id); end
        req = '0;
        tick();
        req = 4'b1111;
        tick();
        n_vec++; if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            n_bad++; $display("FAIL wrap_ptr: got gnt=%b id=%0d expected 0010/1", gnt, gnt_id); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            model_edge();
            n_vec++; if (gnt !== m_gnt || wr_en !== m_wr_en) begin
                n_bad++; $display("FAIL rand_gnt[%0d]: got gnt=%b wr_en=%b expected %b/%b", c, gnt, wr_en, m_gnt, m_wr_en); end
            n_vec++; if (wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin
                n_bad++; $display("FAIL rand_wr[%0d]: got addr=%0d data=%h expected %0d/%h", c, wr_addr, wr_data, m_wr_addr, m_wr_data); end
            if (m_wr_en) begin
                n_vec++; if (gnt_id !== IW'(m_gnt_id)) begin
                    n_bad++; $display("FAIL rand_id[%0d]: got %0d expected %0d", c, gnt_id, m_gnt_id); end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && m_gnt[i]) begin
                    req[i] = ($urandom_range(1, 0) == 1);
                    if (req[i]) set_req(i, AW'($urandom_range(NREG - 1, 0)), DW'($urandom));
                end else if (!req[i] && $urandom_range(2, 0) == 0) begin
                    req[i] = 1'b1;
                    set_req(i, AW'($urandom_range(NREG - 1, 0)), DW'($urandom));
                end
            end
            if ($urandom_range(15, 0) == 0) prio_mode = ~prio_mode;
            rd_addr = AW'($urandom_range(NREG - 1, 0));
            #1;
            n_vec++; if (rd_data !== m_bank[rd_addr] || busy !== (|req)) begin
                n_bad++; $display("FAIL rand_rd[%0d]: got rd=%h busy=%b expected %h/%b", c, rd_data, busy, m_bank[rd_addr], |req); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_priority();
        test_collision();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regbank_wr_arbiter.md
# regbank_wr_arbiter

Shared write-port controller for the processor's 8-bit register bank. Up to NREQ requesters (decode, ALU writeback, load unit, debug) each present an address/data write request; the block picks one per cycle by round-robin or fixed priority, acknowledges it, and commits the write into an internal bank of NREG 8-bit registers. A combinational read port serves the operand fetch path.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- NREG, 8, number of 8-bit registers; power of two; AW = log2(NREG)
- DW, 8, register data width

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (req[0] highest)
- req  input  NREQ  per-requester write request, level
- req_addr  input  NREQ*AW  packed target addresses, slice i = requester i
- req_data  input  NREQ*DW  packed write data, slice i = requester i
- gnt  output  NREQ  one-hot grant pulse, registered
- gnt_id  output  log2(NREQ)  index of current grant, valid while wr_en = 1
- wr_en  output  1  write commit strobe, registered
- wr_addr  output  AW  address being committed
- wr_data  output  DW  data being committed
- rd_addr  input  AW  read address
- rd_data  output  DW  bank[rd_addr], combinational
- busy  output  1  |req, combinational

## Operation
- Requester i raises req[i] with req_addr/req_data stable; holds them until it samples gnt[i] = 1. It may then drop req[i] or present a new transaction the same cycle.
- Eligible set: elig = req & ~gnt (a requester is masked in the cycle its grant is visible, preventing double grant on a stale request).
- Round-robin: pointer ptr (log2(NREQ) bits) marks highest priority; search elig from ptr upward, wrapping modulo NREQ. After granting i, ptr <= (i+1) mod NREQ. ptr does not move when nothing is granted.
- Fixed priority: lowest-index eligible requester wins; ptr still updates on every grant so switching back to round-robin resumes fairly.
- prio_mode sampled combinationally each cycle; a change affects the next arbitration.
- On a grant to i at an edge: gnt <= one-hot(i), gnt_id <= i, wr_en <= 1, wr_addr/wr_data <= requester i's slices. With no eligible requester: gnt <= 0, wr_en <= 0, wr_addr/wr_data/gnt_id hold.
- Commit: at the edge after wr_en = 1, bank[wr_addr] <= wr_data.
- rd_data reflects bank contents only; no bypass of the in-flight write. Read of the address being committed returns old data until the commit edge.
- Reset: ptr, gnt, gnt_id, wr_en, wr_addr, wr_data and every bank entry cleared to 0. rd_data = 0 for all addresses. A write in flight when rst rises is dropped; no grant is issued while rst = 1.

## Timing
- Arbitration cycle N (req high) -> gnt/wr_en high cycle N+1 -> data readable on rd_data cycle N+2.
- Throughput: one write per cycle aggregate; a single requester alone is granted at most every other cycle (masking).
- Grant is a one-cycle pulse; wr_en may stay high on consecutive cycles for different requesters.
- Two requesters to the same address in consecutive cycles: both commit in grant order; later one wins.
- All outputs except rd_data and busy are registered; rst release takes effect asynchronously, first grant possible at the first edge after release.

## Test plan
- Reset: write bank via requester 0, assert rst mid-cycle with wr_en = 1 -> all outputs 0 immediately, rd_data = 0 at every address, dropped write never appears.
- Single write: req[2]=1, addr 5, data 0xA7 -> gnt = 4'b0100 and wr_en one cycle later, rd_addr = 5 reads 0xA7 two cycles after request; no second grant while req[2] stays high one extra cycle.
- Round-robin: all four req held high, prio_mode = 0 -> grant order 0,1,2,3,0,... one per cycle, gnt_id matches.
- Fixed priority: req = 4'b1010 held, prio_mode = 1 -> grants alternate 1,3,1,3 (masking); switching to prio_mode = 0 resumes from ptr.
- Same-address collision: req[0] addr 3 data 0x11 and req[1] addr 3 data 0x22 together, round-robin from ptr 0 -> commits 0x11 then 0x22; final rd_data at addr 3 = 0x22.
- Wrap: ptr = 3, req = 4'b1001 -> grant 3 then 0; ptr ends at 1.
